// File: rtl/dmem_bytelane.sv
// dmem_bytelane: RV32I data memory with byte/halfword/word loads and stores.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset (clears the response path only)
//   req_i      access request, one per cycle at most
//   we_i       1 = store, 0 = load (qualified by req_i)
//   funct3_i   RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i     byte address
//   wdata_i    right-aligned store data
//   rvalid_o   one-cycle response strobe for the previous cycle's request
//   rdata_o    extended load data; 0 for stores, errors and idle cycles
//   err_o      access rejected (illegal width, misaligned or out of range)
//
// Little-endian layout. Responses are registered one cycle after the request.
module dmem_bytelane #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 32,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [2:0]    funct3_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);

    typedef enum logic {StIdle, StResp} state_e;

    state_e       state_q, state_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;

    logic [31:0]  mem_q [DEPTH_WORDS] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

    logic [IW-1:0] word_idx;
    logic [1:0]    lane;
    logic          legal;
    logic          misaligned;
    logic          out_of_range;
    logic          acc_err;
    logic          wr_en;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;

    assign word_idx = addr_i[IW+1:2];
    assign lane     = addr_i[1:0];

    // Any address bit above the word index makes the access out of range; no aliasing.
    assign out_of_range = (addr_i >> (IW + 2)) != '0;

    always_comb begin
        legal = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~we_i;  // unsigned forms exist for loads only
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = |addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign acc_err = ~legal | misaligned | out_of_range;
    assign wr_en   = req_i & we_i & ~acc_err & ~rst_i;

    // Load path: array read at the request edge, extended data held in rdata_q.
    assign rd_word = mem_q[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        case (funct3_i)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d = req_i ? StResp : StIdle;
        err_d   = req_i & acc_err;
        rdata_d = (req_i & ~we_i & ~acc_err) ? load_data : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory contents survive reset; only the write enable is blocked by it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            case (funct3_i[1:0])
                2'b00:   mem_q[word_idx][{lane, 3'b000} +: 8]     <= wdata_i[7:0];
                2'b01:   mem_q[word_idx][{lane[1], 4'b0000} +: 16] <= wdata_i[15:0];
                default: mem_q[word_idx]                           <= wdata_i;
            endcase
        end
    end

    // Reset also squashes a response already in flight during the reset cycle.
    assign rvalid_o = (state_q == StResp) & ~rst_i;
    assign rdata_o  = rst_i ? 32'h0 : rdata_q;
    assign err_o    = err_q & ~rst_i;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed cases followed by random traffic,
// all compared against a byte-array reference model.
module tb_dmem_bytelane;

    localparam int unsigned Depth = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    dmem_bytelane #(
        .DEPTH_WORDS(Depth),
        .AW         (32),
        .INIT_ZERO  (1'b1)
    ) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .funct3_i(funct3),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .err_o   (err)
    );

    logic [7:0]  mem_m [Depth*4];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        case (f3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd4, 3'd5:       legal = !w;
            default:          legal = 1'b0;
        endcase
        if (!legal) return 1'b1;
        if (a % acc_size(f3) != 0) return 1'b1;
        return a >= Depth * 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < acc_size(f3); i++) v = v + (32'(mem_m[a + i]) << (8 * i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // One clock cycle: drive inputs, check the response owed from the previous cycle,
    // then update the model with this cycle's request.
    task automatic step(input bit r, input bit q, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; req = q; we = w; funct3 = f3; addr = a; wdata = d;
        #1;
        if (r) begin
            exp_valid = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
        end
        check("rvalid", {31'h0, rvalid}, {31'h0, exp_valid});
        check("err", {31'h0, err}, {31'h0, exp_err});
        check("rdata", rdata, exp_rdata);
        if (r || !q) begin
            exp_valid = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
        end else begin
            exp_valid = 1'b1;
            exp_err   = ref_err(w, f3, a);
            exp_rdata = (exp_err || w) ? 32'h0 : ref_load(f3, a);
            if (!exp_err && w)
                for (int i = 0; i < acc_size(f3); i++) mem_m[a + i] = d[8*i +: 8];
        end
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, f3, a, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    // Issue one access, move to its response cycle, and compare against fixed values.
    task automatic acc_chk(input string tag, input bit w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] ed, input bit ee);
        step(1'b0, 1'b1, w, f3, a, d);
        idle();
        check({tag, "_valid"}, {31'h0, rvalid}, 32'h1);
        check({tag, "_rdata"}, rdata, ed);
        check({tag, "_err"}, {31'h0, err}, {31'h0, ee});
    endtask

    initial begin
        for (int i = 0; i < Depth * 4; i++) mem_m[i] = 8'h00;
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        exp_valid = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;

        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        idle();

        // Word store/load and store response carrying zero data.
        acc_chk("sw10", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        acc_chk("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Sub-word stores and sign/zero-extended loads.
        st(3'd0, 32'h11, 32'h0000_007F);
        st(3'd1, 32'h12, 32'h0000_8001);
        acc_chk("lw_merge", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8001_7FEF, 1'b0);
        acc_chk("lb13", 1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
        acc_chk("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
        acc_chk("lh12", 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0);
        acc_chk("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, 32'h0000_8001, 1'b0);

        // Misaligned and illegal encodings.
        acc_chk("lw_mis", 1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1);
        acc_chk("sh_mis", 1'b1, 3'd1, 32'h11, 32'h0000_AAAA, 32'h0, 1'b1);
        acc_chk("lw_after_sh_mis", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8001_7FEF, 1'b0);
        acc_chk("ld_f3_011", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
        acc_chk("st_f3_100", 1'b1, 3'd4, 32'h10, 32'h1234_5678, 32'h0, 1'b1);
        acc_chk("lw_after_bad_st", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8001_7FEF, 1'b0);

        // Range boundary: top word legal, 0x400 rejected and not aliased to word 0.
        acc_chk("lw400", 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
        st(3'd2, 32'h3FC, 32'h1234_5678);
        acc_chk("lw3fc", 1'b0, 3'd2, 32'h3FC, 32'h0, 32'h1234_5678, 1'b0);
        st(3'd2, 32'h0, 32'h1111_1111);
        acc_chk("sw400", 1'b1, 3'd2, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b1);
        acc_chk("lw0_noalias", 1'b0, 3'd2, 32'h0, 32'h0, 32'h1111_1111, 1'b0);

        // Back-to-back loads and idle gaps.
        st(3'd2, 32'h4, 32'h2222_2222);
        st(3'd2, 32'h8, 32'h3333_3333);
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'h4, 32'h0);
        check("b2b0", rdata, 32'h1111_1111);
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'h8, 32'h0);
        check("b2b1", rdata, 32'h2222_2222);
        idle();
        check("b2b2", rdata, 32'h3333_3333);
        check("b2b2_valid", {31'h0, rvalid}, 32'h1);
        idle();
        check("gap_valid", {31'h0, rvalid}, 32'h0);
        check("gap_rdata", rdata, 32'h0);

        // Reset squashes an in-flight load, blocks stores, and preserves memory.
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        check("rst_squash_valid", {31'h0, rvalid}, 32'h0);
        check("rst_squash_rdata", rdata, 32'h0);
        step(1'b1, 1'b1, 1'b1, 3'd2, 32'h10, 32'h0BAD_F00D);
        idle();
        check("post_rst_valid", {31'h0, rvalid}, 32'h0);
        acc_chk("lw_after_rst", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8001_7FEF, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = $urandom_range(0, 63);
                7:                   a = 32'h3F0 + $urandom_range(0, 15);
                8:                   a = 32'h400 + $urandom_range(0, 15);
                default:             a = $urandom;
            endcase
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
                 3'($urandom), a, $urandom);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised RV32I data memory: the successor of the word-only data RAM. It adds byte and halfword loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW), sign and zero extension, registered reads with a valid strobe, and error reporting for misaligned, out-of-range and illegal-width accesses. It sits between the MEM stage (address from the ALU, store data from rs2, funct3 from the decoder) and the writeback mux.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- AW, 32: width of the `addr` port.
- INIT_ZERO, 1: when 1, all words are 0 at simulation start; when 0, contents are undefined.

Ports:
- clk  in  1  rising-edge clock; one clock for the whole block.
- rst  in  1  reset; synchronous and active-high.
- req  in  1  access request, valid this cycle; at most one access per cycle.
- we  in  1  1 = store, 0 = load; qualified by `req`.
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  AW  byte address.
- wdata  in  32  store data, right-aligned (rs2).
- rvalid  out  1  one-cycle pulse: response for the request of the previous cycle.
- rdata  out  32  extended load data; 0 for stores and errored accesses.
- err  out  1  valid with `rvalid`; 1 = access rejected.

## Operation
- Layout:
  - Memory is little-endian.
  - Word index = `addr[log2(DEPTH_WORDS)+1:2]`.
  - Byte lane = `addr[1:0]`.
- Legal encodings:
  - Loads: funct3 ∈ {000, 001, 010, 100, 101}.
  - Stores: funct3 ∈ {000, 001, 010}.
  - Any other encoding is illegal.
- Misaligned access:
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` ≠ 00.
- Out of range: any `addr` bit above `log2(DEPTH_WORDS)+1` is nonzero. There is no aliasing.
- Error (`err` = 1) when the access is illegal, misaligned or out of range:
  - no memory write occurs;
  - `rdata` = 0.
- Store, no error: only the addressed lanes are written; all other bytes of the word are preserved.
  - SB: `wdata[7:0]` into lane `addr[1:0]`.
  - SH: `wdata[15:0]` into lanes `addr[1]*2` and `+1`.
  - SW: all four lanes.
- Load, no error:
  - The selected byte or halfword is shifted to bit 0.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW returns the full word.
- Response states, one register stage:
  - IDLE: no response this cycle.
  - RESP: response presented (`rvalid` = 1).
  - Next state is RESP when `req` was 1 in the previous cycle, IDLE otherwise.
  - Back-to-back requests produce back-to-back RESP cycles.
- Stores also produce `rvalid` (with `rdata` = 0) so the pipeline can retire them uniformly.
- `req` = 0: `we`, `funct3`, `addr` and `wdata` are ignored.

## Timing
- Reset values: `rvalid` = 0, `rdata` = 0, `err` = 0. Memory contents are not affected by reset.
- Load latency is 1 cycle: a request at edge N is answered with `rvalid`/`rdata`/`err` valid after edge N, during cycle N+1.
- A store commits at the edge where `req` & `we` is sampled. A load issued in the next cycle to the same word returns the new data.
- The array is read synchronously: the read address is registered, or the array is read at the same edge. `rdata` is the extended data held in a register; there is no combinational path from `addr` to `rdata`.
- Outputs return to 0 in every cycle with no response: `rdata` = 0 and `err` = 0 when `rvalid` = 0.
- Reset during operation:
  - A request sampled while `rst` = 1 is discarded: no write, no response.
  - The response to a request accepted in the cycle before reset asserts is suppressed; outputs are 0 in the cycle after the reset edge.
- Address wrap: there is none. Out-of-range addresses report `err`; they never wrap to low words.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `rvalid` 1 cycle after the load, `rdata` = 0xDEADBEEF, `err` = 0. The store's own response has `rdata` = 0.
- After the SW above, SB 0x7F @0x11 and SH 0x8001 @0x12 → LW @0x10 = 0x80017FEF.
  - LB @0x13 = 0xFFFFFF80; LBU @0x13 = 0x00000080.
  - LH @0x12 = 0xFFFF8001; LHU @0x12 = 0x00008001.
- Misaligned and illegal accesses:
  - LW @0x12 → `err` = 1, `rdata` = 0.
  - SH @0x11 of 0xAAAA → `err` = 1; a following LW @0x10 is unchanged.
  - funct3 = 011 load → `err` = 1.
  - Store with funct3 = 100 → `err` = 1, no write.
- With DEPTH_WORDS = 256: LW @0x400 → `err` = 1. LW @0x3FC after SW 0x12345678 @0x3FC → 0x12345678. A write to 0x400 does not change word 0.
- Back-to-back loads @0x0, 0x4, 0x8 in consecutive cycles → three consecutive `rvalid` pulses carrying the data in order. `req` = 0 gaps → `rvalid` = 0, `rdata` = 0.
- Reset cases:
  - Assert `rst` in the cycle after a load request → no `rvalid`; outputs 0.
  - SW with `rst` = 1 → memory unchanged.
  - Memory written before reset is still readable after reset.
